// File: rtl/trace_buffer_capture_ctrl.sv
// rtl/trace_buffer_capture_ctrl.sv - trace buffer write-address/enable controller with capture modes and readback addressing
module trace_buffer_capture_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  trig,
    input  logic [1:0]            mode,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [ADDR_WIDTH-1:0] depth_limit,
    input  logic [CNT_WIDTH-1:0]  post_count,
    input  logic [31:0]           rd_offset,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [NUM_CH-1:0]     wr_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  bram_en,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_CONT    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_TRIG    = 2'd2;

    state_t                state;
    state_t                next_state;
    logic [1:0]            mode_q;
    logic [NUM_CH-1:0]     mask_q;
    logic [ADDR_WIDTH-1:0] limit_q;
    logic [CNT_WIDTH-1:0]  post_q;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [ADDR_WIDTH-1:0] ptr;

    logic                  capturing;
    logic                  write;
    logic                  at_limit;
    logic                  trig_hit;
    logic [ADDR_WIDTH:0]   depth;
    logic [ADDR_WIDTH:0]   offset;
    logic [ADDR_WIDTH:0]   offset_mod;
    logic [ADDR_WIDTH:0]   rd_sum;
    logic [ADDR_WIDTH-1:0] oldest;
    logic [ADDR_WIDTH-1:0] rd_next;
    logic                  unused_rd_offset_hi;

    assign bram_en             = 1'b1;
    assign busy                = (state == RUN) || (state == POST);
    assign unused_rd_offset_hi = ^rd_offset[31:ADDR_WIDTH];

    assign capturing = (state == RUN) || (state == POST);
    assign write     = !arm && capturing && sample_en;
    assign at_limit  = (ptr == limit_q);
    assign trig_hit  = (state == RUN) && (mode_q == MODE_TRIG) && trig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (arm) begin
            next_state = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (stop) begin
                        next_state = DONE;
                    end else if (sample_en) begin
                        if (mode_q == MODE_ONESHOT && at_limit) begin
                            next_state = DONE;
                        end else if (trig_hit) begin
                            next_state = (post_q == '0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (stop || (sample_en && remaining == '0)) begin
                        next_state = DONE;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // Offsets at or beyond the depth need a true modulo; the sum of two
    // in-range values only ever needs a single conditional subtract.
    always_comb begin
        depth      = {1'b0, limit_q} + (ADDR_WIDTH+1)'(1);
        offset     = {1'b0, rd_offset[ADDR_WIDTH-1:0]};
        offset_mod = (offset >= depth) ? (offset % depth) : offset;
        oldest     = wrapped ? ptr : '0;
        rd_sum     = {1'b0, oldest} + offset_mod;
        if (rd_sum >= depth) begin
            rd_sum = rd_sum - depth;
        end
        rd_next = (state == IDLE) ? rd_offset[ADDR_WIDTH-1:0] : rd_sum[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_CONT;
            mask_q       <= '0;
            limit_q      <= '0;
            post_q       <= '0;
            remaining    <= '0;
            ptr          <= '0;
            wr_addr      <= '0;
            wr_en        <= '0;
            rd_addr      <= '0;
            done         <= 1'b0;
            wrapped      <= 1'b0;
            trig_addr    <= '0;
            sample_count <= '0;
        end else begin
            wr_en   <= '0;
            rd_addr <= rd_next;
            if (arm) begin
                mode_q       <= (mode == 2'd3) ? MODE_CONT : mode;
                mask_q       <= ch_mask;
                limit_q      <= depth_limit;
                post_q       <= post_count;
                remaining    <= '0;
                ptr          <= '0;
                done         <= 1'b0;
                wrapped      <= 1'b0;
                trig_addr    <= '0;
                sample_count <= '0;
            end else begin
                if (write) begin
                    wr_addr <= ptr;
                    wr_en   <= mask_q;
                    if (sample_count != '1) begin
                        sample_count <= sample_count + CNT_WIDTH'(1);
                    end
                    if (at_limit) begin
                        ptr <= '0;
                        // A one-shot capture ends on this write, so it never counts as a wrap.
                        if (mode_q != MODE_ONESHOT) begin
                            wrapped <= 1'b1;
                        end
                    end else begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                    end
                    if (trig_hit) begin
                        trig_addr <= ptr;
                        remaining <= post_q - CNT_WIDTH'(1);
                    end else if (state == POST && remaining != '0) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                    end
                end
                if (next_state == DONE && state != DONE) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_buffer_capture_ctrl.sv
// tb/tb_trace_buffer_capture_ctrl.sv - directed self-checking bench for trace_buffer_capture_ctrl
module tb_trace_buffer_capture_ctrl;

    localparam int NUM_CH     = 4;
    localparam int ADDR_WIDTH = 15;
    localparam int CNT_WIDTH  = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  sample_en;
    logic                  arm;
    logic                  stop;
    logic                  trig;
    logic [1:0]            mode;
    logic [NUM_CH-1:0]     ch_mask;
    logic [ADDR_WIDTH-1:0] depth_limit;
    logic [CNT_WIDTH-1:0]  post_count;
    logic [31:0]           rd_offset;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_CH-1:0]     wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  bram_en;
    logic                  busy;
    logic                  done;
    logic                  wrapped;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic [CNT_WIDTH-1:0]  sample_count;

    int checks = 0;
    int errors = 0;

    trace_buffer_capture_ctrl #(
        .NUM_CH(NUM_CH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_en(sample_en),
        .arm(arm),
        .stop(stop),
        .trig(trig),
        .mode(mode),
        .ch_mask(ch_mask),
        .depth_limit(depth_limit),
        .post_count(post_count),
        .rd_offset(rd_offset),
        .wr_addr(wr_addr),
        .wr_en(wr_en),
        .rd_addr(rd_addr),
        .bram_en(bram_en),
        .busy(busy),
        .done(done),
        .wrapped(wrapped),
        .trig_addr(trig_addr),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [3:0] msk,
                          input logic [ADDR_WIDTH-1:0] lim, input logic [CNT_WIDTH-1:0] pc);
        mode = m; ch_mask = msk; depth_limit = lim; post_count = pc;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_en = 0; arm = 0; stop = 0; trig = 0;
        mode = 0; ch_mask = 0; depth_limit = 0; post_count = 0; rd_offset = 0;
        cyc(); cyc();
        rst = 1'b0;
        checks++;
        if ({wr_addr, wr_en, rd_addr, busy, done, wrapped, trig_addr} !== '0 || sample_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wr_addr=%0d wr_en=%b rd_addr=%0d busy=%b done=%b wrapped=%b trig_addr=%0d cnt=%0d, want all 0",
                     wr_addr, wr_en, rd_addr, busy, done, wrapped, trig_addr, sample_count);
        end
        checks++;
        if (bram_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_bram_en: got %b want 1", bram_en);
        end
    endtask

    task automatic test_continuous();
        logic [ADDR_WIDTH-1:0] exp_ptr;
        do_arm(2'd0, 4'b1011, 15'd7, 0);
        for (int i = 0; i < 10; i++) begin
            sample_en = 1'b1;
            cyc();
            sample_en = 1'b0;
            exp_ptr = ADDR_WIDTH'(i % 8);
            checks++;
            if (wr_addr !== exp_ptr || wr_en !== 4'b1011) begin
                errors++;
                $display("FAIL cont_write%0d: wr_addr=%0d wr_en=%b want %0d/1011", i, wr_addr, wr_en, exp_ptr);
            end
            checks++;
            if (wrapped !== (i >= 7)) begin
                errors++;
                $display("FAIL cont_wrapped%0d: got %b want %b", i, wrapped, (i >= 7));
            end
            cyc();
            checks++;
            if (wr_en !== 4'b0000) begin
                errors++;
                $display("FAIL cont_idle%0d: wr_en=%b want 0000", i, wr_en);
            end
        end
        checks++;
        if (rd_addr !== 15'd2) begin
            errors++;
            $display("FAIL cont_rd_off0: rd_addr=%0d want 2", rd_addr);
        end
        rd_offset = 32'd6;
        cyc();
        checks++;
        if (rd_addr !== 15'd0) begin
            errors++;
            $display("FAIL cont_rd_off6: rd_addr=%0d want 0", rd_addr);
        end
        rd_offset = 32'hFFFF_000D;
        cyc();
        checks++;
        if (rd_addr !== 15'd7) begin
            errors++;
            $display("FAIL cont_rd_off13: rd_addr=%0d want 7", rd_addr);
        end
        rd_offset = 0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || sample_count !== 32'd10) begin
            errors++;
            $display("FAIL cont_stop: busy=%b done=%b cnt=%0d want 0/1/10", busy, done, sample_count);
        end
    endtask

    task automatic test_one_shot();
        do_arm(2'd1, 4'b1111, 15'd3, 0);
        for (int i = 0; i < 6; i++) begin
            sample_en = 1'b1;
            cyc();
            sample_en = 1'b0;
            checks++;
            if (wr_en !== ((i < 4) ? 4'b1111 : 4'b0000) || (i < 4 && wr_addr !== ADDR_WIDTH'(i))) begin
                errors++;
                $display("FAIL oneshot_write%0d: wr_addr=%0d wr_en=%b", i, wr_addr, wr_en);
            end
            cyc();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_count !== 32'd4 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_status: done=%b busy=%b cnt=%0d wrapped=%b want 1/0/4/0",
                     done, busy, sample_count, wrapped);
        end
    endtask

    task automatic test_triggered();
        do_arm(2'd2, 4'b0001, 15'd15, 32'd3);
        for (int i = 0; i < 9; i++) begin
            sample_en = 1'b1;
            trig = (i == 4);
            cyc();
            sample_en = 1'b0;
            trig = 1'b0;
            checks++;
            if (i < 8) begin
                if (wr_addr !== ADDR_WIDTH'(i) || wr_en !== 4'b0001 || done !== (i == 7)) begin
                    errors++;
                    $display("FAIL trig_write%0d: wr_addr=%0d wr_en=%b done=%b", i, wr_addr, wr_en, done);
                end
            end else if (wr_en !== 4'b0000) begin
                errors++;
                $display("FAIL trig_after_done: wr_en=%b want 0000", wr_en);
            end
            cyc();
        end
        checks++;
        if (trig_addr !== 15'd4 || sample_count !== 32'd8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL trig_status: trig_addr=%0d cnt=%0d busy=%b want 4/8/0", trig_addr, sample_count, busy);
        end
    endtask

    task automatic test_post_zero();
        do_arm(2'd2, 4'b0010, 15'd15, 32'd0);
        sample_en = 1'b1;
        trig = 1'b1;
        cyc();
        sample_en = 1'b0;
        trig = 1'b0;
        checks++;
        if (wr_en !== 4'b0010 || wr_addr !== 15'd0 || done !== 1'b1 || busy !== 1'b0 || trig_addr !== 15'd0) begin
            errors++;
            $display("FAIL post0: wr_en=%b wr_addr=%0d done=%b busy=%b trig_addr=%0d want 0010/0/1/0/0",
                     wr_en, wr_addr, done, busy, trig_addr);
        end
        sample_en = 1'b1;
        cyc();
        sample_en = 1'b0;
        checks++;
        if (wr_en !== 4'b0000 || sample_count !== 32'd1) begin
            errors++;
            $display("FAIL post0_after: wr_en=%b cnt=%0d want 0000/1", wr_en, sample_count);
        end
    endtask

    task automatic test_back_to_back();
        sample_en = 1'b1;
        do_arm(2'd0, 4'b0110, 15'd7, 0);
        sample_en = 1'b0;
        checks++;
        if (wr_en !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL arm_with_strobe: wr_en=%b busy=%b done=%b want 0000/1/0", wr_en, busy, done);
        end
        sample_en = 1'b1;
        cyc();
        checks++;
        if (wr_en !== 4'b0110 || wr_addr !== 15'd0) begin
            errors++;
            $display("FAIL b2b_first: wr_en=%b wr_addr=%0d want 0110/0", wr_en, wr_addr);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        sample_en = 1'b0;
        checks++;
        if (wr_en !== 4'b0110 || wr_addr !== 15'd1 || done !== 1'b1 || busy !== 1'b0 || sample_count !== 32'd2) begin
            errors++;
            $display("FAIL stop_with_strobe: wr_en=%b wr_addr=%0d done=%b busy=%b cnt=%0d want 0110/1/1/0/2",
                     wr_en, wr_addr, done, busy, sample_count);
        end
    endtask

    task automatic test_single_entry();
        do_arm(2'd0, 4'b0001, 15'd0, 0);
        for (int i = 0; i < 2; i++) begin
            sample_en = 1'b1;
            cyc();
            sample_en = 1'b0;
            checks++;
            if (wr_addr !== 15'd0 || wr_en !== 4'b0001 || wrapped !== 1'b1) begin
                errors++;
                $display("FAIL single_entry%0d: wr_addr=%0d wr_en=%b wrapped=%b want 0/0001/1", i, wr_addr, wr_en, wrapped);
            end
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_arm(2'd2, 4'b1111, 15'd15, 32'd5);
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1;
            trig = (i == 1);
            cyc();
            sample_en = 1'b0;
            trig = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || trig_addr !== 15'd1) begin
            errors++;
            $display("FAIL post_before_rst: busy=%b trig_addr=%0d want 1/1", busy, trig_addr);
        end
        rst = 1'b1;
        sample_en = 1'b1;
        cyc();
        rst = 1'b0;
        sample_en = 1'b0;
        checks++;
        if ({wr_addr, wr_en, rd_addr, busy, done, wrapped, trig_addr} !== '0 || sample_count !== '0) begin
            errors++;
            $display("FAIL rst_mid: wr_addr=%0d wr_en=%b rd_addr=%0d busy=%b done=%b wrapped=%b trig_addr=%0d cnt=%0d, want all 0",
                     wr_addr, wr_en, rd_addr, busy, done, wrapped, trig_addr, sample_count);
        end
        do_arm(2'd0, 4'b1111, 15'd3, 0);
        sample_en = 1'b1;
        cyc();
        sample_en = 1'b0;
        checks++;
        if (wr_addr !== 15'd0 || wr_en !== 4'b1111) begin
            errors++;
            $display("FAIL rearm_after_rst: wr_addr=%0d wr_en=%b want 0/1111", wr_addr, wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_triggered();
        test_post_zero();
        test_back_to_back();
        test_single_entry();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
